bsg_two_fifo_width_p84: RTL and testbench

BSG_TWO_FIFO_WIDTH_P84 -- requirements
Module: bsg_two_fifo_width_p84

---
 rtl/bsg_two_fifo_width_p84_if.sv | 29 ++
 rtl/bsg_two_fifo_width_p84.sv | 104 ++++++++++
 tb/tb_bsg_two_fifo_width_p84.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bsg_two_fifo_width_p84_if.sv
// rtl/bsg_two_fifo_width_p84_if.sv - producer/consumer handshake bundle for the two-entry FIFO
interface bsg_two_fifo_width_p84_if #(
    parameter int width_p = 84
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;

    modport master (
        output v_i,
        output data_i,
        output yumi_i,
        input  ready_o,
        input  v_o,
        input  data_o
    );

    modport slave (
        input  v_i,
        input  data_i,
        input  yumi_i,
        output ready_o,
        output v_o,
        output data_o
    );
endinterface

// File: rtl/bsg_two_fifo_width_p84.sv
// rtl/bsg_two_fifo_width_p84.sv - two-entry FIFO, registered ready/valid, no fall-through
module bsg_two_fifo_width_p84 #(
    parameter int width_p = 84,
    parameter int els_p   = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bsg_two_fifo_width_p84_if.slave   io
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_wptr;
    logic               r_rptr;
    logic               r_full;
    logic               r_ready;
    logic               r_v;
    logic [width_p-1:0] r_mem [els_p];

    logic w_enq;
    logic w_deq;

    // Handshakes qualify only against registered state, so ready_o never sees yumi_i.
    assign w_enq = io.v_i & r_ready;
    assign w_deq = io.yumi_i & r_v;

    assign io.ready_o = r_ready;
    assign io.v_o     = r_v;
    assign io.data_o  = r_mem[r_rptr];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_EMPTY;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_v     <= 1'b0;
            for (int i = 0; i < els_p; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_mem[r_wptr] <= io.data_i;
            end
            r_wptr <= r_wptr ^ w_enq;
            r_rptr <= r_rptr ^ w_deq;

            unique case (r_state)
                S_EMPTY: begin
                    r_full  <= 1'b0;
                    r_ready <= 1'b1;
                    if (w_enq) begin
                        r_state <= S_ONE;
                        r_v     <= 1'b1;
                    end else begin
                        r_state <= S_EMPTY;
                        r_v     <= 1'b0;
                    end
                end
                S_ONE: begin
                    if (w_enq && !w_deq) begin
                        r_state <= S_FULL;
                        r_full  <= 1'b1;
                        r_ready <= 1'b0;
                        r_v     <= 1'b1;
                    end else if (w_deq && !w_enq) begin
                        r_state <= S_EMPTY;
                        r_full  <= 1'b0;
                        r_ready <= 1'b1;
                        r_v     <= 1'b0;
                    end else begin
                        r_state <= S_ONE;
                        r_full  <= 1'b0;
                        r_ready <= 1'b1;
                        r_v     <= 1'b1;
                    end
                end
                S_FULL: begin
                    r_v <= 1'b1;
                    if (w_deq) begin
                        r_state <= S_ONE;
                        r_full  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_FULL;
                        r_full  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_full  <= 1'b0;
                    r_ready <= 1'b1;
                    r_v     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_two_fifo_width_p84.sv
// tb/tb_bsg_two_fifo_width_p84.sv - scoreboard bench for the two-entry FIFO
module tb_bsg_two_fifo_width_p84;
    localparam int W = 84;

    logic clk_i;
    logic reset_i;

    bsg_two_fifo_width_p84_if #(.width_p(W)) io ();

    bsg_two_fifo_width_p84 #(.width_p(W), .els_p(2)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .io      (io)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sb_q[$];
    bit           armed = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: an occupancy-limited queue of two; the cycle right
    // after reset release is not yet ready.
    always @(negedge clk_i) begin
        if (reset_i) begin
            sb_q.delete();
            armed = 0;
            chk("rst_v_o",     W'(io.v_o),     '0);
            chk("rst_ready_o", W'(io.ready_o), '0);
            chk("rst_data_o",  io.data_o,      '0);
        end else if (!armed) begin
            chk("rel_ready_o", W'(io.ready_o), '0);
            chk("rel_v_o",     W'(io.v_o),     '0);
            armed = 1;
        end else begin
            bit deq;
            bit enq;
            chk("ready_o", W'(io.ready_o), W'(sb_q.size() < 2));
            chk("v_o",     W'(io.v_o),     W'(sb_q.size() > 0));
            if (sb_q.size() > 0) chk("data_o", io.data_o, sb_q[0]);
            deq = io.yumi_i && (sb_q.size() > 0);
            enq = io.v_i && (sb_q.size() < 2);
            if (deq) void'(sb_q.pop_front());
            if (enq) sb_q.push_back(io.data_i);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit y);
        io.v_i    = v;
        io.data_i = d;
        io.yumi_i = y;
        tick();
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    initial begin
        io.v_i    = 1'b0;
        io.data_i = '0;
        io.yumi_i = 1'b0;
        reset_i   = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        chk("post_reset_ready", W'(io.ready_o), W'(1));
        chk("post_reset_v",     W'(io.v_o),     W'(0));

        // single enqueue, 1-cycle latency
        drive(1, W'(84'h1), 0);
        io.v_i = 0;
        chk("one_v_o",     W'(io.v_o),     W'(1));
        chk("one_data_o",  io.data_o,      W'(84'h1));
        chk("one_ready_o", W'(io.ready_o), W'(1));
        drive(0, '0, 1);

        // fill, drop while full, drain
        drive(1, W'(84'hA), 0);
        drive(1, W'(84'hB), 0);
        chk("full_ready_o", W'(io.ready_o), W'(0));
        chk("full_data_o",  io.data_o,      W'(84'hA));
        drive(1, W'(84'hC), 0);
        chk("drop_data_o",  io.data_o,      W'(84'hA));
        drive(0, '0, 1);
        chk("drain1_data_o",  io.data_o,      W'(84'hB));
        chk("drain1_ready_o", W'(io.ready_o), W'(1));
        drive(0, '0, 1);
        chk("drain2_v_o", W'(io.v_o), W'(0));

        // simultaneous enqueue/dequeue in ONE
        drive(1, W'(84'h5), 0);
        drive(1, W'(84'h6), 1);
        chk("sim_v_o",     W'(io.v_o),     W'(1));
        chk("sim_data_o",  io.data_o,      W'(84'h6));
        chk("sim_ready_o", W'(io.ready_o), W'(1));
        drive(0, '0, 1);

        // yumi while empty is ignored
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1);
            chk("empty_yumi_v_o", W'(io.v_o), W'(0));
        end
        drive(1, W'(84'h7), 0);
        chk("after_empty_data_o", io.data_o, W'(84'h7));
        drive(0, '0, 1);

        // async reset while full
        drive(1, W'(84'h11), 0);
        drive(1, W'(84'h22), 0);
        io.v_i = 0;
        #3 reset_i = 1'b1;
        #1;
        chk("async_v_o",     W'(io.v_o),     W'(0));
        chk("async_ready_o", W'(io.ready_o), W'(0));
        chk("async_data_o",  io.data_o,      W'(0));
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk("rerel_ready_o", W'(io.ready_o), W'(1));
        chk("rerel_v_o",     W'(io.v_o),     W'(0));

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), rnd_data(), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) drive(0, '0, 1);
        chk("final_v_o", W'(io.v_o), W'(0));
        chk("final_sb_empty", W'(sb_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
